// File: rtl/fetch_unit.sv
// fetch_unit: Thumb instruction fetch stage sitting in front of Memory.
// Owns the PC, issues one 32-bit word read per fetch, then hands the
// decoder the two little-endian halfwords of that word over valid/ready.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   mem_addr          word-aligned read address {pc[31:2],2'b00}
//   mem_rd_en         one-cycle read strobe (FETCH state)
//   mem_rdata         read data, valid MEM_LATENCY cycles after the strobe
//   instr, instr_pc   current halfword and its byte address
//   instr_valid       instr/instr_pc valid
//   instr_ready       decoder accepts instr this cycle
//   branch_valid      redirect request (pulse or held)
//   branch_target     redirect address, bit 0 ignored
//
// Parameters:
//   RESET_PC          PC after reset (bit 0 forced to 0)
//   MEM_LATENCY       strobe-to-data latency in cycles, 1..4

module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [31:0] mem_rdata,
    output logic [15:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch_valid,
    input  logic [31:0] branch_target
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [31:0] PC_INIT = {RESET_PC[31:1], 1'b0};

    // wait_cnt counts down the remaining WAIT cycles; the word is
    // captured in the WAIT cycle where it reaches zero.
    localparam logic [2:0] WAIT_INIT = 3'(MEM_LATENCY - 1);

    state_t      state;
    logic [31:0] pc;
    logic [2:0]  wait_cnt;
    logic [31:0] word_buf;

    logic        in_hold;
    logic [15:0] half_sel;
    logic        unused_tgt_lsb;

    // Branch target bit 0 is architecturally meaningless for Thumb.
    assign unused_tgt_lsb = branch_target[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= PC_INIT;
            state    <= FETCH;
            wait_cnt <= 3'd0;
            word_buf <= 32'd0;
        end else if (branch_valid) begin
            // Redirect wins over everything: any read already issued is
            // simply never captured because we leave WAIT behind.
            pc       <= {branch_target[31:1], 1'b0};
            state    <= FETCH;
            wait_cnt <= 3'd0;
        end else begin
            unique case (state)
                FETCH: begin
                    wait_cnt <= WAIT_INIT;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        word_buf <= mem_rdata;
                        state    <= HOLD;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        pc <= pc + 32'd2;
                        // Upper halfword consumed: the word is used up.
                        if (pc[1]) begin
                            state <= FETCH;
                        end
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    assign in_hold  = (state == HOLD);
    assign half_sel = pc[1] ? word_buf[31:16] : word_buf[15:0];

    // Valid is gated combinationally by branch so a redirect can never
    // coincide with a completed handshake.
    assign instr_valid = in_hold && !rst && !branch_valid;
    assign instr       = instr_valid ? half_sel : 16'd0;
    assign instr_pc    = pc;
    assign mem_rd_en   = (state == FETCH) && !rst;
    assign mem_addr    = {pc[31:2], 2'b00};

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit, two instances
// (MEM_LATENCY 1 and 3) checked every cycle against a timing model.

module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ready;
    logic        br;
    logic [31:0] tgt;

    logic [1:0][31:0] addr_w;
    logic [1:0]       rd_en_w;
    logic [1:0][31:0] rdata_w;
    logic [1:0][15:0] instr_w;
    logic [1:0][31:0] ipc_w;
    logic [1:0]       valid_w;

    fetch_unit #(.RESET_PC(32'h4), .MEM_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .mem_addr(addr_w[0]), .mem_rd_en(rd_en_w[0]),
        .mem_rdata(rdata_w[0]),
        .instr(instr_w[0]), .instr_pc(ipc_w[0]),
        .instr_valid(valid_w[0]), .instr_ready(ready),
        .branch_valid(br), .branch_target(tgt)
    );

    fetch_unit #(.RESET_PC(32'h4), .MEM_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst),
        .mem_addr(addr_w[1]), .mem_rd_en(rd_en_w[1]),
        .mem_rdata(rdata_w[1]),
        .instr(instr_w[1]), .instr_pc(ipc_w[1]),
        .instr_valid(valid_w[1]), .instr_ready(ready),
        .branch_valid(br), .branch_target(tgt)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h4) return 32'h2010_fcfb;
        return {a[15:0] + 16'h1002, a[15:0] + 16'h3000};
    endfunction

    function automatic logic [15:0] half_at(input logic [31:0] p);
        logic [31:0] w;
        w = mem_word({p[31:2], 2'b00});
        return p[1] ? w[31:16] : w[15:0];
    endfunction

    task automatic chk(input string nm, input int k,
                       input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s[dut%0d] cyc=%0d got=%h exp=%h",
                     nm, lat(k), cyc, got, exp);
        end
    endtask

    // Memory: a read issued at cycle F returns its word during F+L;
    // any other cycle shows junk so mis-timed captures are visible.
    logic [3:0]  pv [2];
    logic [31:0] pa [2][4];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            pv[k] <= {pv[k][2:0], rd_en_w[k]};
            pa[k][0] <= addr_w[k];
            for (int j = 1; j < 4; j++) pa[k][j] <= pa[k][j-1];
        end
    end

    always_comb begin
        rdata_w = '0;
        for (int k = 0; k < 2; k++) begin
            if (pv[k][lat(k)-1] === 1'b1)
                rdata_w[k] = mem_word(pa[k][lat(k)-1]);
            else
                rdata_w[k] = {16'hDEAD, cyc[15:0]};
        end
    end

    // Model: PC plus the cycle of the strobe for the current word.
    // The word is deliverable from strobe+L+1 on; nothing else matters.
    logic [31:0] m_pc [2];
    int          m_fa [2];
    bit          m_known = 1'b0;

    function automatic bit e_valid(input int k);
        return !rst && !br && (cyc >= m_fa[k] + lat(k) + 1);
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_pc[k] <= 32'h4;
                m_fa[k] <= cyc + 1;
            end else if (br) begin
                m_pc[k] <= {tgt[31:1], 1'b0};
                m_fa[k] <= cyc + 1;
            end else if (e_valid(k) && ready) begin
                m_pc[k] <= m_pc[k] + 32'd2;
                if (m_pc[k][1]) m_fa[k] <= cyc + 1;
            end
        end
        if (rst) m_known <= 1'b1;
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (m_known) begin
            for (int k = 0; k < 2; k++) begin
                logic        ev;
                logic [15:0] ei;
                ev = e_valid(k);
                ei = ev ? half_at(m_pc[k]) : 16'd0;
                chk("valid", k, 32'(valid_w[k]), 32'(ev));
                chk("instr", k, 32'(instr_w[k]), 32'(ei));
                chk("instr_pc", k, ipc_w[k], m_pc[k]);
                chk("rd_en", k, 32'(rd_en_w[k]),
                    32'(!rst && cyc == m_fa[k]));
                chk("addr", k, addr_w[k], {m_pc[k][31:2], 2'b00});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic hold_chk(input logic [31:0] p, input logic [15:0] h);
        chk("d_valid", 0, 32'(valid_w[0]), 32'd1);
        chk("d_ipc", 0, ipc_w[0], p);
        chk("d_instr", 0, 32'(instr_w[0]), 32'(h));
    endtask

    initial begin
        rst = 1'b1; ready = 1'b1; br = 1'b0; tgt = '0;
        tick(); tick();
        rst = 1'b0; settle();
        for (int k = 0; k < 2; k++) begin
            chk("d_rd_en", k, 32'(rd_en_w[k]), 32'd1);
            chk("d_addr", k, addr_w[k], 32'h4);
        end
        tick();
        tick(); settle(); hold_chk(32'h4, 16'hfcfb);
        tick(); settle(); hold_chk(32'h6, 16'h2010);
        tick(); settle();
        chk("d_rd_en", 0, 32'(rd_en_w[0]), 32'd1);
        chk("d_addr", 0, addr_w[0], 32'h8);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick(); ready = 1'b0; settle();
            hold_chk(32'h8, 16'h3008);
            chk("d_rd_en", 0, 32'(rd_en_w[0]), 32'd0);
        end
        tick(); ready = 1'b1; settle(); hold_chk(32'h8, 16'h3008);
        tick(); br = 1'b1; tgt = 32'h13; settle();
        chk("d_ipc", 0, ipc_w[0], 32'hA);
        chk("d_valid", 0, 32'(valid_w[0]), 32'd0);
        tick(); br = 1'b0; settle();
        chk("d_addr", 0, addr_w[0], 32'h10);
        tick();
        tick(); settle(); hold_chk(32'h12, 16'h1012);
        tick(); br = 1'b1; tgt = 32'hFFFF_FFFC; settle();
        chk("d_rd_en", 0, 32'(rd_en_w[0]), 32'd1);
        chk("d_addr", 0, addr_w[0], 32'h14);
        tick(); br = 1'b0; settle();
        chk("d_addr", 0, addr_w[0], 32'hFFFF_FFFC);
        tick();
        tick(); settle(); hold_chk(32'hFFFF_FFFC, 16'h2FFC);
        tick(); settle(); hold_chk(32'hFFFF_FFFE, 16'h0FFE);
        tick(); br = 1'b1; tgt = 32'h100; settle();
        chk("d_addr", 0, addr_w[0], 32'h0);
        chk("d_rd_en", 0, 32'(rd_en_w[0]), 32'd1);
        tick(); tgt = 32'h200;
        tick(); tgt = 32'h41;
        tick(); br = 1'b0; settle();
        chk("d_addr", 0, addr_w[0], 32'h40);
        tick();
        tick(); settle(); hold_chk(32'h40, 16'h3040);
        tick(); rst = 1'b1; br = 1'b1; tgt = 32'h80; settle();
        chk("d_valid", 0, 32'(valid_w[0]), 32'd0);
        chk("d_rd_en", 0, 32'(rd_en_w[0]), 32'd0);
        chk("d_instr", 0, 32'(instr_w[0]), 32'd0);
        tick(); rst = 1'b0; br = 1'b0; settle();
        for (int k = 0; k < 2; k++) begin
            chk("d_ipc", k, ipc_w[k], 32'h4);
            chk("d_rd_en", k, 32'(rd_en_w[k]), 32'd1);
        end
        tick();
        tick(); br = 1'b1; tgt = 32'h200; settle();
        chk("d_valid", 0, 32'(valid_w[0]), 32'd0);
        tick(); br = 1'b0; settle();
        chk("d_rd_en", 1, 32'(rd_en_w[1]), 32'd1);
        chk("d_addr", 1, addr_w[1], 32'h200);
        for (int i = 0; i < 3; i++) begin
            tick(); settle();
            chk("d_valid", 1, 32'(valid_w[1]), 32'd0);
        end
        tick(); settle();
        chk("d_valid", 1, 32'(valid_w[1]), 32'd1);
        chk("d_ipc", 1, ipc_w[1], 32'h200);
        chk("d_instr", 1, 32'(instr_w[1]), 32'h3200);
        for (int i = 0; i < 300; i++) begin
            tick();
            ready = ($urandom_range(0, 3) != 0);
            br = ($urandom_range(0, 15) == 0);
            tgt = (i % 5 == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7)))
                               : $urandom;
            rst = ($urandom_range(0, 63) == 0);
        end
        tick(); rst = 1'b0; br = 1'b0; ready = 1'b1;
        repeat (10) tick();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
